// File: rtl/switch_pkg.sv
// Shared constants for the switch-board front-end: chain length, default
// timing/debounce parameters and the frame sequencer state encoding.
package switch_pkg;

   localparam int SW_WIDTH            = 16;
   localparam int DEF_CLK_DIV         = 4;
   localparam int DEF_DEBOUNCE_FRAMES = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_SHIFT = 2'd2;
   localparam state_t ST_EVAL  = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: raises tick for one clock every CLK_DIV clocks.
// The first tick lands CLK_DIV clocks after reset is released.
module tick_gen
   import switch_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..CLK_DIV-1 and wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/switch_shift_reader.sv
// Switch-board front-end. Drives a 74HC165-style PISO chain (load, then
// 2 ticks per bit), assembles each frame MSB-first, debounces frames and
// presents a stable registered word to the LED driver.
//
// Every sequencer move happens on a tick. "sub" is the second half of each
// two-tick step: the second IDLE/LOAD/EVAL tick, or phase B of a bit.
// Frame timeline in ticks, T0 = load released:
//   T1,T3..T31 phase A (sample ser_in), T2..T32 phase B (sr_clk high),
//   T33 first EVAL tick (debounce, frame_valid), T34 load asserted,
//   T36 load released again.
module switch_shift_reader
   import switch_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int CLK_DIV         = DEF_CLK_DIV,
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ser_in,
   output logic             sr_load_n,
   output logic             sr_clk,
   output logic [WIDTH-1:0] switch_data,
   output logic             frame_valid,
   output logic             changed
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES - 1);

   logic             tick;
   state_t           state;
   logic             sub;
   logic [IDX_W-1:0] bit_idx;
   logic [WIDTH-1:0] frame;
   logic [WIDTH-1:0] last_frame;
   logic [CNT_W-1:0] stable_cnt;
   logic             eval_tick;
   logic [WIDTH-1:0] next_last;
   logic [CNT_W-1:0] next_cnt;
   logic             take;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign eval_tick = tick && (state == ST_EVAL) && !sub;

   // Frame sequencer: chain control strobes, bit capture, frame_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sub         <= 1'b0;
         bit_idx     <= '0;
         frame       <= '0;
         sr_load_n   <= 1'b1;
         sr_clk      <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (tick) begin
            sub <= ~sub;
            case (state)
               ST_IDLE: begin
                  if (sub) begin
                     state     <= ST_LOAD;
                     sr_load_n <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  if (sub) begin
                     state     <= ST_SHIFT;
                     sr_load_n <= 1'b1;
                     bit_idx   <= '0;
                  end
               end
               ST_SHIFT: begin
                  if (!sub) begin
                     // First bit out of the chain lands in the MSB.
                     frame[IDX_LAST - bit_idx] <= ser_in;
                     sr_clk                    <= 1'b0;
                  end else begin
                     sr_clk <= 1'b1;
                     if (bit_idx == IDX_LAST) begin
                        state <= ST_EVAL;
                     end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                     end
                  end
               end
               ST_EVAL: begin
                  if (!sub) begin
                     sr_clk      <= 1'b0;
                     frame_valid <= 1'b1;
                  end else begin
                     state     <= ST_LOAD;
                     sr_load_n <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Debounce step for the frame just captured: extend or restart the run.
   always_comb begin
      next_last = last_frame;
      next_cnt  = stable_cnt;
      if (frame == last_frame) begin
         if (stable_cnt != CNT_MAX) begin
            next_cnt = stable_cnt + CNT_W'(1);
         end
      end else begin
         next_last = frame;
         next_cnt  = '0;
      end
      take = (next_cnt == CNT_MAX) && (next_last != switch_data);
   end

   // Debounce state and the published word, updated once per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_frame  <= '0;
         stable_cnt  <= '0;
         switch_data <= '0;
         changed     <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (eval_tick) begin
            last_frame <= next_last;
            stable_cnt <= next_cnt;
            if (take) begin
               switch_data <= next_last;
               changed     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_shift_reader.sv
// Bench for switch_shift_reader: two instances (default timing, and the
// fast CLK_DIV=2 / DEBOUNCE_FRAMES=1 corner), each with a behavioural
// 74HC165 chain and a frame-history reference model.
module tb_switch_shift_reader;

   localparam int W         = 16;
   localparam int CLK_DIV_A = 4;
   localparam int DF_A      = 4;
   localparam int CLK_DIV_B = 2;
   localparam int DF_B      = 1;
   localparam int PER_A     = (2 + 2 * W + 2) * CLK_DIV_A;
   localparam int PER_B     = (2 + 2 * W + 2) * CLK_DIV_B;
   localparam int FV_BUDGET = 1000;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- DUT A (defaults) ----------------
   logic         ser_a, load_n_a, sr_clk_a, fv_a, ch_a;
   logic [W-1:0] sw_data_a;
   logic [W-1:0] sw_a     = '0;
   logic [W-1:0] chain_a  = '0;
   logic [W-1:0] loaded_a = '0;

   switch_shift_reader #(
      .WIDTH           (W),
      .CLK_DIV         (CLK_DIV_A),
      .DEBOUNCE_FRAMES (DF_A)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .ser_in      (ser_a),
      .sr_load_n   (load_n_a),
      .sr_clk      (sr_clk_a),
      .switch_data (sw_data_a),
      .frame_valid (fv_a),
      .changed     (ch_a)
   );

   // ---------------- DUT B (fast corner) ----------------
   logic         ser_b, load_n_b, sr_clk_b, fv_b, ch_b;
   logic [W-1:0] sw_data_b;
   logic [W-1:0] sw_b     = '0;
   logic [W-1:0] chain_b  = '0;
   logic [W-1:0] loaded_b = '0;

   switch_shift_reader #(
      .WIDTH           (W),
      .CLK_DIV         (CLK_DIV_B),
      .DEBOUNCE_FRAMES (DF_B)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .ser_in      (ser_b),
      .sr_load_n   (load_n_b),
      .sr_clk      (sr_clk_b),
      .switch_data (sw_data_b),
      .frame_valid (fv_b),
      .changed     (ch_b)
   );

   // ---------------- 74HC165 chain models ----------------
   // Load is level-sensitive (sw is held steady while load is low);
   // Q7 (the MSB) is the serial output.
   always @(posedge sr_clk_a or negedge load_n_a) begin
      if (!load_n_a) begin
         chain_a  <= sw_a;
         loaded_a <= sw_a;
      end else begin
         chain_a <= {chain_a[W-2:0], 1'b0};
      end
   end
   assign ser_a = chain_a[W-1];

   always @(posedge sr_clk_b or negedge load_n_b) begin
      if (!load_n_b) begin
         chain_b  <= sw_b;
         loaded_b <= sw_b;
      end else begin
         chain_b <= {chain_b[W-2:0], 1'b0};
      end
   end
   assign ser_b = chain_b[W-1];

   int edges_a = 0;
   int edges_b = 0;
   always @(posedge sr_clk_a) edges_a++;
   always @(posedge sr_clk_b) edges_b++;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // True when the last n frames are all the same value.
   function automatic bit run_done(input logic [W-1:0] q[$], input int n);
      if (q.size() < n) return 1'b0;
      foreach (q[i]) if (q[i] !== q[0]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- scoreboards ----------------
   logic [W-1:0] hist_a[$];
   logic [W-1:0] exp_a = '0;
   bit           upd_a, have_a;
   int           fv_cyc_a, fv_edges_a;
   int           chg_a = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hist_a.delete();
         exp_a  = '0;
         have_a = 1'b0;
      end else begin
         if (!load_n_a) check("interlock_a", 32'(sr_clk_a), 0);
         if (ch_a && !fv_a) check("chg_alone_a", 1, 0);
         if (fv_a) begin
            hist_a.push_back(loaded_a);
            if (hist_a.size() > DF_A) void'(hist_a.pop_front());
            upd_a = run_done(hist_a, DF_A) && (hist_a[0] != exp_a);
            if (upd_a) exp_a = hist_a[0];
            check("data_a", 32'(sw_data_a), 32'(exp_a));
            check("chg_a", 32'(ch_a), 32'(upd_a));
            if (ch_a) chg_a++;
            if (have_a) begin
               check("period_a", cyc - fv_cyc_a, PER_A);
               check("edges_a", edges_a - fv_edges_a, W);
            end
            fv_cyc_a   = cyc;
            fv_edges_a = edges_a;
            have_a     = 1'b1;
         end
      end
   end

   logic [W-1:0] hist_b[$];
   logic [W-1:0] exp_b = '0;
   bit           upd_b, have_b;
   int           fv_cyc_b, fv_edges_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         hist_b.delete();
         exp_b  = '0;
         have_b = 1'b0;
      end else begin
         if (!load_n_b) check("interlock_b", 32'(sr_clk_b), 0);
         if (ch_b && !fv_b) check("chg_alone_b", 1, 0);
         if (fv_b) begin
            hist_b.push_back(loaded_b);
            if (hist_b.size() > DF_B) void'(hist_b.pop_front());
            upd_b = run_done(hist_b, DF_B) && (hist_b[0] != exp_b);
            if (upd_b) exp_b = hist_b[0];
            check("data_b", 32'(sw_data_b), 32'(exp_b));
            check("chg_b", 32'(ch_b), 32'(upd_b));
            if (have_b) begin
               check("period_b", cyc - fv_cyc_b, PER_B);
               check("edges_b", edges_b - fv_edges_b, W);
            end
            fv_cyc_b   = cyc;
            fv_edges_b = edges_b;
            have_b     = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_fv_a();
      bit seen = 1'b0;
      for (int n = 0; n < FV_BUDGET && !seen; n++) begin
         @(negedge clk);
         seen = fv_a;
      end
      if (!seen) check("fv_timeout_a", 0, 1);
      #1;
   endtask

   task automatic wait_fv_b();
      bit seen = 1'b0;
      for (int n = 0; n < FV_BUDGET && !seen; n++) begin
         @(negedge clk);
         seen = fv_b;
      end
      if (!seen) check("fv_timeout_b", 0, 1);
      #1;
   endtask

   // Present a switch value starting with the next frame, hold n frames.
   task automatic frames_a(input logic [W-1:0] v, input int n);
      sw_a = v;
      repeat (n) wait_fv_a();
   endtask

   task automatic frames_b(input logic [W-1:0] v, input int n);
      sw_b = v;
      repeat (n) wait_fv_b();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_load_n_a"}, 32'(load_n_a), 1);
      check({tag, "_sr_clk_a"}, 32'(sr_clk_a), 0);
      check({tag, "_data_a"},   32'(sw_data_a), 0);
      check({tag, "_fv_a"},     32'(fv_a), 0);
      check({tag, "_ch_a"},     32'(ch_a), 0);
      check({tag, "_load_n_b"}, 32'(load_n_b), 1);
      check({tag, "_sr_clk_b"}, 32'(sr_clk_b), 0);
      check({tag, "_data_b"},   32'(sw_data_b), 0);
   endtask

   // Count clocks from release until the first load strobe.
   task automatic check_first_load(input string tag);
      int  n    = 0;
      bit  seen = 1'b0;
      while (n < 50 && !seen) begin
         @(negedge clk);
         n++;
         seen = !load_n_a;
      end
      check(tag, n, 2 * CLK_DIV_A);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] v;
      logic [W-1:0] prev;
      int           c0;

      // Reset, then bit order with a stable 16'hA5C3.
      sw_a = 16'hA5C3;
      repeat (5) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      check_first_load("first_load_a");
      repeat (3) wait_fv_a();
      check("pre_acq_a", 32'(sw_data_a), 0);
      wait_fv_a();
      check("acq_data_a", 32'(sw_data_a), 32'h0000A5C3);
      check("acq_chg_a", 32'(ch_a), 1);
      c0 = chg_a;
      frames_a(16'hA5C3, 10);
      check("no_rechg_a", chg_a - c0, 0);

      // Glitch shorter than the debounce window is rejected.
      frames_a(16'h00FF, 5);
      check("stable_00ff", 32'(sw_data_a), 32'h000000FF);
      c0 = chg_a;
      frames_a(16'h01FF, 2);
      frames_a(16'h00FF, 4);
      check("reject_data", 32'(sw_data_a), 32'h000000FF);
      check("reject_chg", chg_a - c0, 0);

      // A held change is accepted on the 4th frame, not before.
      frames_a(16'hFF00, 3);
      check("accept_early", 32'(sw_data_a), 32'h000000FF);
      wait_fv_a();
      check("accept_data", 32'(sw_data_a), 32'h0000FF00);
      check("accept_chg", 32'(ch_a), 1);

      // Random runs of frames, including repeats and short glitches.
      prev = 16'hFF00;
      repeat (14) begin
         v = ($urandom_range(0, 3) == 0) ? prev : W'($urandom_range(0, 16'hFFFF));
         frames_a(v, $urandom_range(1, 6));
         prev = v;
      end

      // Reset in the middle of bit 7 of a frame.
      frames_a(16'h3C3C, 4);
      check("pre_rst_data", 32'(sw_data_a), 32'h00003C3C);
      repeat (77) @(negedge clk);
      check("pre_rst_sclk", 32'(sr_clk_a), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(sw_data_a), 0);
      check("mid_rst_sclk", 32'(sr_clk_a), 0);
      check("mid_rst_load", 32'(load_n_a), 1);
      repeat (3) @(negedge clk);
      check_reset_outputs("rst2");
      rst_n = 1'b1;
      check_first_load("first_load_a2");
      repeat (3) wait_fv_a();
      check("reacq_early", 32'(sw_data_a), 0);
      wait_fv_a();
      check("reacq_data", 32'(sw_data_a), 32'h00003C3C);
      check("reacq_chg", 32'(ch_a), 1);

      // Fast corner: a single differing frame updates immediately.
      wait_fv_b();
      frames_b(16'h8001, 1);
      check("fast_data_b", 32'(sw_data_b), 32'h00008001);
      check("fast_chg_b", 32'(ch_b), 1);
      repeat (8) frames_b(W'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
